// File: rtl/mem_stream_loader_pkg.sv
// Shared definitions for the memory stream loader: op codes, bank indices and FSM state encoding.
package mem_stream_loader_pkg;

    localparam logic MSL_OP_WRITE = 1'b0;
    localparam logic MSL_OP_READ  = 1'b1;

    localparam int BANK_IMEM    = 0;
    localparam int BANK_SCALAR  = 1;
    localparam int BANK_BATCH   = 2;
    localparam int BANK_ENCODED = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } msl_state_e;

endpackage

// File: rtl/msl_skid_fifo.sv
// Two-entry skid FIFO that absorbs read data returning from the banks while the consumer stalls.
module msl_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot [2];
    logic              wr_sel;
    logic              rd_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_sel] <= push_data;
                wr_sel       <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head is only written by a push into an empty slot, so it holds still while stalled.
    assign head = slot[rd_sel];

endmodule

// File: rtl/mem_stream_loader.sv
// Command-driven burst engine that loads/dumps accelerator memories over valid/ready streams.
// Optional running checksum enabled by defining MSL_CHECKSUM_EN.
module mem_stream_loader
    import mem_stream_loader_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int BANK_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [BANK_W-1:0]           cmd_bank,
    input  logic [ADDR_W-1:0]           cmd_base,
    input  logic [ADDR_W:0]             cmd_len,
    input  logic                        cmd_abort,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [NUM_BANKS-1:0]        mem_we,
    output logic [NUM_BANKS-1:0]        mem_re,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
    output logic                        busy,
    output logic                        done,
    output logic                        pipe_hold,
    output logic [DATA_W-1:0]           checksum,
    output msl_state_e                  state_dbg
);

    // All streams transfer a word on a cycle where valid and ready are both high at the
    // rising edge; valid never depends on ready, and an offered word stays put until taken.

    msl_state_e        state, state_nxt;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   rem_q;
    logic              inflight_q;
    logic              done_q;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              accept, wr_beat, issue, pop, last;
    logic [2:0]        occ;

    assign accept  = (state == ST_IDLE) && cmd_valid;
    assign wr_beat = (state == ST_WRITE) && s_valid && !cmd_abort;
    assign pop     = m_valid && m_ready;
    // A word leaving this cycle frees its slot, which keeps reads streaming one per cycle.
    assign occ     = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (state == ST_READ) && !cmd_abort && (occ < 3'd2);
    assign last    = (rem_q == {{ADDR_W{1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    state_nxt = (cmd_op == MSL_OP_READ) ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cmd_abort) begin
                    state_nxt = ST_DRAIN;
                end else if (wr_beat && last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cmd_abort || (issue && last)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_count == 2'd0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        s_ready   = (state == ST_WRITE) && !cmd_abort;
        busy      = (state != ST_IDLE);
        mem_we    = '0;
        mem_re    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_beat) begin
            mem_we[bank_q] = 1'b1;
            mem_addr       = ptr_q;
            mem_wdata      = s_data;
        end
        if (issue) begin
            mem_re[bank_q] = 1'b1;
            mem_addr       = ptr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q     <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                bank_q <= cmd_bank;
                ptr_q  <= cmd_base;
                rem_q  <= cmd_len;
            end else if (wr_beat || issue) begin
                ptr_q <= ptr_q + 1'b1;
                rem_q <= rem_q - 1'b1;
            end
            inflight_q <= issue;
            done_q     <= (accept && (cmd_len == '0)) ||
                          ((state != ST_IDLE) && (state_nxt == ST_IDLE));
        end
    end

    msl_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (mem_rdata[bank_q*DATA_W +: DATA_W]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign m_valid   = (fifo_count != 2'd0);
    assign m_data    = fifo_head;
    assign done      = done_q;
    assign pipe_hold = busy;
    assign state_dbg = state;

`ifdef MSL_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_q + (wr_beat ? s_data : '0) + (pop ? m_data : '0);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule
